// File: rtl/pingpong_transpose_buf.sv
// Ping-pong N x N register-bank transpose buffer: rows are written into one bank while
// the other bank is drained column by column (or row by row when TRANSPOSE=0).
module pingpong_transpose_buf #(
  parameter int unsigned N         = 8,
  parameter int unsigned EW        = 8,
  parameter bit          TRANSPOSE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [N*EW-1:0] wr_data,
  input  logic [N-1:0]    wr_be,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [N*EW-1:0] rd_data,
  output logic            rd_last,
  output logic [1:0]      bank_full
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = N * EW;

  logic [EW-1:0] mem [2][N][N];

  logic          wr_bank;
  logic          rd_bank;
  logic [IW-1:0] wr_row;
  logic [IW-1:0] rd_col;

  logic          wr_fire;
  logic          wr_wrap;
  logic          fetch;
  logic          rd_wrap;
  logic [1:0]    bank_full_nxt;
  logic [DW-1:0] rd_word;

  assign wr_ready = ~bank_full[wr_bank];
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_wrap  = (wr_row == IW'(N - 1));
  assign fetch    = bank_full[rd_bank] & (~rd_valid | rd_ready);
  assign rd_wrap  = (rd_col == IW'(N - 1));

  // Storage is never reset; per-element byte enables keep old contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      for (int unsigned e = 0; e < N; e++) begin
        if (wr_be[e]) begin
          mem[wr_bank][wr_row][e] <= wr_data[e*EW +: EW];
        end
      end
    end
  end

  // Gather one column (or row) of the read bank into a beat.
  always_comb begin
    rd_word = '0;
    for (int unsigned r = 0; r < N; r++) begin
      if (TRANSPOSE) begin
        rd_word[r*EW +: EW] = mem[rd_bank][r][rd_col];
      end else begin
        rd_word[r*EW +: EW] = mem[rd_bank][rd_col][r];
      end
    end
  end

  // Set and clear always hit different banks, so both apply in the same cycle.
  always_comb begin
    bank_full_nxt = bank_full;
    if (fetch && rd_wrap) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
    if (wr_fire && wr_wrap) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_row    <= '0;
      rd_col    <= '0;
      bank_full <= 2'b00;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else begin
      bank_full <= bank_full_nxt;

      if (wr_fire) begin
        if (wr_wrap) begin
          wr_row  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row  <= wr_row + IW'(1);
        end
      end

      // Single output register: refill whenever empty or being consumed.
      if (fetch) begin
        rd_data  <= rd_word;
        rd_valid <= 1'b1;
        rd_last  <= rd_wrap;
        if (rd_wrap) begin
          rd_col  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_col  <= rd_col + IW'(1);
        end
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

endmodule
